tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op_valid  input  1  MEM-stage TLB instruction present.
REQ-004 SHALL have port: op_type  input  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-005 SHALL have ports: cp0_index  input  4  Index[3:0]; cp0_wired  input  4  Wired[3:0]; cp0_wired_we  input  1  Wired write strobe.
REQ-006 SHALL have port: cp0_entry  input  90  packed EntryHi/PageMask/EntryLo0/EntryLo1 in TLB entry layout.
REQ-007 SHALL have ports: tlb_req  output  1; tlb_we  output  1; tlb_probe  output  1; tlb_idx  output  4; tlb_wdata  output  90.
REQ-008 SHALL have ports: tlb_ack  input  1; tlb_rdata  input  90; probe_hit  input  1; probe_idx  input  4.
REQ-009 SHALL have ports: stall  output  1; cp0_entry_we  output  1; cp0_entry_wdata  output  90; cp0_index_we  output  1; cp0_index_wdata  output  32; cp0_random  output  4; op_err  output  1.

Function
REQ-010 SHALL implement FSM IDLE, BUSY, DONE (plus ABORT when REQ-027 enabled).
REQ-011 SHALL move IDLE->BUSY on op_valid; latch op_type, target index (cp0_index for TLBR/TLBWI, cp0_random for TLBWR) and cp0_entry.
REQ-012 SHALL, in BUSY, hold tlb_req=1 with tlb_idx, tlb_wdata = latched values; tlb_we=1 only for TLBWI/TLBWR; tlb_probe=1 only for TLBP.
REQ-013 SHALL move BUSY->DONE in the cycle tlb_ack=1; capture tlb_rdata, probe_hit, probe_idx that cycle.
REQ-014 SHALL, in DONE, pulse for exactly one cycle: cp0_entry_we=1 with cp0_entry_wdata=captured tlb_rdata for TLBR; cp0_index_we=1 with cp0_index_wdata={~hit,27'b0,probe_idx} for TLBP (on miss: bit31=1, bits[3:0]=0); no CP0 write for TLBWI/TLBWR; then DONE->IDLE.
REQ-015 SHALL drive stall = (IDLE & op_valid) | BUSY; stall=0 in DONE so MEM advances in the writeback cycle.
REQ-016 SHALL give minimum latency op_valid -> DONE of 2 cycles (ack in first BUSY cycle); stall high for 2 cycles minimum.
REQ-017 SHALL ignore op_valid outside IDLE; a new op accepted in IDLE cycle after DONE.
REQ-018 SHALL keep tlb_req/tlb_we/tlb_probe=0 outside BUSY; tlb_ack outside BUSY ignored.
REQ-019 SHALL hold cp0_random: each cycle, if cp0_wired_we then 15; else if cp0_random==cp0_wired then 15; else cp0_random-1.
REQ-020 SHALL, if cp0_wired==15, hold cp0_random at 15; if cp0_random<cp0_wired (after Wired raised), continue decrementing to 0 then wrap to 15.
REQ-021 SHALL use the random value sampled at acceptance (REQ-011), unaffected by later decrements.

Reset
REQ-022 SHALL, on rst, enter IDLE; stall, tlb_req, tlb_we, tlb_probe, cp0_entry_we, cp0_index_we, op_err=0; tlb_idx=0; tlb_wdata, cp0_entry_wdata=0; cp0_index_wdata=0; cp0_random=15.
REQ-023 SHALL abandon any in-flight op on rst (including BUSY with tlb_ack same cycle): no CP0 write pulse.
REQ-024 SHALL give rst priority over cp0_wired_we and op_valid.

Configuration
REQ-025 SHALL honour macro TLB_OP_TIMEOUT_EN.
REQ-026 SHALL, without TLB_OP_TIMEOUT_EN, wait in BUSY indefinitely for tlb_ack; op_err tied 0.
REQ-027 SHALL, with TLB_OP_TIMEOUT_EN, count BUSY cycles (5-bit, cleared on entry); at 16 cycles without ack go to ABORT: one-cycle op_err=1, stall=0, no CP0 write, then IDLE; ack in 16th cycle wins over timeout.

Verification
REQ-028 SHALL cover: TLBR, cp0_index=5, ack 1st BUSY cycle, tlb_rdata=X -> tlb_idx=5, tlb_we=0, cp0_entry_we pulse 1 cycle with X, stall high 2 cycles.
REQ-029 SHALL cover: TLBP miss (probe_hit=0) -> cp0_index_wdata=0x80000000; hit idx 9 -> 0x00000009.
REQ-030 SHALL cover: Wired=3, 13 cycles after reset -> random 15,14..3,15; TLBWR accepted when random=7 -> tlb_idx=7 throughout BUSY, tlb_we=1.
REQ-031 SHALL cover: TLBWI with ack delayed 4 cycles -> stall high 5 cycles, tlb_req held, op_valid toggles ignored.
REQ-032 SHALL cover: rst asserted in BUSY with tlb_ack=1 -> IDLE next cycle, no cp0 write pulse, cp0_random=15.
REQ-033 SHALL cover (TLB_OP_TIMEOUT_EN): no ack 16 cycles -> op_err pulse, no CP0 write; ack in cycle 16 -> normal DONE, op_err=0.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - MEM-stage TLBP/TLBR/TLBWI/TLBWR sequencer with CP0 Random counter.
// Optional BUSY watchdog enabled by defining TLB_OP_TIMEOUT_EN.
module tlb_op_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [3:0]  cp0_index,
  input  logic [3:0]  cp0_wired,
  input  logic        cp0_wired_we,
  input  logic [89:0] cp0_entry,
  output logic        tlb_req,
  output logic        tlb_we,
  output logic        tlb_probe,
  output logic [3:0]  tlb_idx,
  output logic [89:0] tlb_wdata,
  input  logic        tlb_ack,
  input  logic [89:0] tlb_rdata,
  input  logic        probe_hit,
  input  logic [3:0]  probe_idx,
  output logic        stall,
  output logic        cp0_entry_we,
  output logic [89:0] cp0_entry_wdata,
  output logic        cp0_index_we,
  output logic [31:0] cp0_index_wdata,
  output logic [3:0]  cp0_random,
  output logic        op_err
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  op_q;
  logic [3:0]  idx_q;
  logic [89:0] entry_q;
  logic [89:0] rdata_q;
  logic [31:0] index_wdata_q;
  logic [3:0]  random_q;

  logic        accept;
  logic        ack_busy;

  assign accept   = (state == S_IDLE) && op_valid;
  assign ack_busy = (state == S_BUSY) && tlb_ack;

`ifdef TLB_OP_TIMEOUT_EN
  logic [4:0] busy_cnt;
  logic       timeout;

  // Counts completed BUSY cycles; reads 15 during the 16th BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst || state != S_BUSY) busy_cnt <= 5'd0;
    else                        busy_cnt <= busy_cnt + 5'd1;
  end

  assign timeout = (busy_cnt == 5'd15);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (op_valid) state_nxt = S_BUSY;
      S_BUSY: begin
        if (tlb_ack) state_nxt = S_DONE;
`ifdef TLB_OP_TIMEOUT_EN
        else if (timeout) state_nxt = S_ABORT;
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tlb_req      = (state == S_BUSY);
    tlb_we       = (state == S_BUSY) && op_q[1];
    tlb_probe    = (state == S_BUSY) && (op_q == OP_TLBP);
    stall        = accept || (state == S_BUSY);
    cp0_entry_we = (state == S_DONE) && (op_q == OP_TLBR);
    cp0_index_we = (state == S_DONE) && (op_q == OP_TLBP);
`ifdef TLB_OP_TIMEOUT_EN
    op_err       = (state == S_ABORT);
`else
    op_err       = 1'b0;
`endif
  end

  // Operands are frozen at acceptance so later Random decrements cannot move a TLBWR.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= 2'b00;
      idx_q         <= 4'd0;
      entry_q       <= '0;
      rdata_q       <= '0;
      index_wdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_type;
        idx_q   <= (op_type == OP_TLBWR) ? random_q : cp0_index;
        entry_q <= cp0_entry;
      end
      if (ack_busy) begin
        rdata_q       <= tlb_rdata;
        index_wdata_q <= {~probe_hit, 27'b0, (probe_hit ? probe_idx : 4'd0)};
      end
    end
  end

  // Random walks down to Wired then reloads 15; below Wired it wraps through 0.
  always_ff @(posedge clk) begin
    if (rst)                       random_q <= 4'd15;
    else if (cp0_wired_we)         random_q <= 4'd15;
    else if (random_q == cp0_wired) random_q <= 4'd15;
    else                           random_q <= random_q - 4'd1;
  end

  assign tlb_idx         = idx_q;
  assign tlb_wdata       = entry_q;
  assign cp0_entry_wdata = rdata_q;
  assign cp0_index_wdata = index_wdata_q;
  assign cp0_random      = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - randomized and directed checks of tlb_op_ctrl against a transaction model.
module tb_tlb_op_ctrl;

  logic        clk;
  logic        r_rst, r_op_valid, r_wired_we, r_ack, r_hit;
  logic [1:0]  r_op_type;
  logic [3:0]  r_index, r_wired, r_pidx;
  logic [89:0] r_entry, r_rdata;

  logic        tlb_req, tlb_we, tlb_probe, stall, cp0_entry_we, cp0_index_we, op_err;
  logic [3:0]  tlb_idx, cp0_random;
  logic [89:0] tlb_wdata, cp0_entry_wdata;
  logic [31:0] cp0_index_wdata;

  tlb_op_ctrl dut (
    .clk(clk), .rst(r_rst), .op_valid(r_op_valid), .op_type(r_op_type),
    .cp0_index(r_index), .cp0_wired(r_wired), .cp0_wired_we(r_wired_we),
    .cp0_entry(r_entry), .tlb_req(tlb_req), .tlb_we(tlb_we), .tlb_probe(tlb_probe),
    .tlb_idx(tlb_idx), .tlb_wdata(tlb_wdata), .tlb_ack(r_ack), .tlb_rdata(r_rdata),
    .probe_hit(r_hit), .probe_idx(r_pidx), .stall(stall), .cp0_entry_we(cp0_entry_we),
    .cp0_entry_wdata(cp0_entry_wdata), .cp0_index_we(cp0_index_we),
    .cp0_index_wdata(cp0_index_wdata), .cp0_random(cp0_random), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one optional in-flight op and one pending writeback.
  int          m_rand;
  bit          m_busy, m_wb, m_abort;
  int          m_bcnt;
  logic [1:0]  m_op;
  logic [3:0]  m_idx;
  logic [89:0] m_entry, m_rdata;
  logic [31:0] m_iw;

  logic        s_stall, s_req, s_we, s_cew, s_ciw, s_err;
  logic [3:0]  s_idx, s_random;
  logic [89:0] s_cewdata;
  logic [31:0] s_ciwdata;

  function automatic logic [89:0] rand90();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[89:0];
  endfunction

  task automatic chk(input string nm, input logic [89:0] act, input logic [89:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rand = 15; m_busy = 0; m_wb = 0; m_abort = 0; m_bcnt = 0;
  endtask

  task automatic model_update();
    int old_rand;
    if (r_rst) begin
      model_reset();
      return;
    end
    old_rand = m_rand;
    if (r_wired_we)                 m_rand = 15;
    else if (m_rand == int'(r_wired)) m_rand = 15;
    else                            m_rand = (m_rand + 15) % 16;
    if (m_abort) m_abort = 0;
    else if (m_wb) m_wb = 0;
    else if (m_busy) begin
      m_bcnt++;
      if (r_ack) begin
        m_busy = 0; m_wb = 1; m_rdata = r_rdata;
        m_iw = r_hit ? {28'b0, r_pidx} : 32'h8000_0000;
      end
`ifdef TLB_OP_TIMEOUT_EN
      else if (m_bcnt == 16) begin
        m_busy = 0; m_abort = 1;
      end
`endif
    end else if (r_op_valid) begin
      m_busy = 1; m_bcnt = 0; m_op = r_op_type; m_entry = r_entry;
      m_idx = (r_op_type == 2'b11) ? 4'(old_rand) : r_index;
    end
  endtask

  // Called #1 after a rising edge with inputs already driven; compares at the falling edge.
  task automatic step();
    bit idle;
    #4;
    idle = !m_busy && !m_wb && !m_abort;
    chk("stall", 90'(stall), 90'((idle && r_op_valid) || m_busy));
    chk("tlb_req", 90'(tlb_req), 90'(m_busy));
    chk("tlb_we", 90'(tlb_we), 90'(m_busy && m_op >= 2'd2));
    chk("tlb_probe", 90'(tlb_probe), 90'(m_busy && m_op == 2'd0));
    chk("cp0_entry_we", 90'(cp0_entry_we), 90'(m_wb && m_op == 2'd1));
    chk("cp0_index_we", 90'(cp0_index_we), 90'(m_wb && m_op == 2'd0));
    chk("op_err", 90'(op_err), 90'(m_abort));
    chk("cp0_random", 90'(cp0_random), 90'(m_rand));
    if (m_busy) begin
      chk("tlb_idx", 90'(tlb_idx), 90'(m_idx));
      chk("tlb_wdata", tlb_wdata, m_entry);
    end
    if (m_wb && m_op == 2'd1) chk("cp0_entry_wdata", cp0_entry_wdata, m_rdata);
    if (m_wb && m_op == 2'd0) chk("cp0_index_wdata", 90'(cp0_index_wdata), 90'(m_iw));
    s_stall = stall; s_req = tlb_req; s_we = tlb_we; s_cew = cp0_entry_we;
    s_ciw = cp0_index_we; s_err = op_err; s_idx = tlb_idx; s_random = cp0_random;
    s_cewdata = cp0_entry_wdata; s_ciwdata = cp0_index_wdata;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    r_rst = 0; r_op_valid = 0; r_wired_we = 0; r_ack = 0; r_hit = 0;
    r_op_type = 0; r_index = 0; r_pidx = 0;
  endtask

  task automatic probe_case(input logic hit, input logic [3:0] pidx, input logic [31:0] exp);
    r_op_valid = 1; r_op_type = 2'b00; step();
    r_op_valid = 0; r_ack = 1; r_hit = hit; r_pidx = pidx; step();
    r_ack = 0; step();
    chk("tlbp_index_we", 90'(s_ciw), 90'(1));
    chk("tlbp_index_wdata", 90'(s_ciwdata), 90'(exp));
    step();
  endtask

  initial begin
    int stall_cnt;
    logic [89:0] xdata;
    bit found;

    quiet(); r_wired = 0; r_entry = '0; r_rdata = '0;
    r_rst = 1;
    @(posedge clk); #1;
    model_reset();
    r_rst = 0;

    // Reset state, pinned literally.
    step();
    chk("rst_random", 90'(s_random), 90'(15));
    chk("rst_stall", 90'(s_stall), 90'(0));
    chk("rst_tlb_idx", 90'(s_idx), 90'(0));
    chk("rst_entry_wdata", s_cewdata, 90'(0));
    chk("rst_index_wdata", 90'(s_ciwdata), 90'(0));
    chk("rst_err", 90'(s_err), 90'(0));

    // TLBR at index 5, immediate ack.
    xdata = rand90();
    stall_cnt = 0;
    r_op_valid = 1; r_op_type = 2'b01; r_index = 4'd5; r_entry = rand90(); step();
    stall_cnt += int'(s_stall);
    r_op_valid = 0; r_ack = 1; r_rdata = xdata; step();
    stall_cnt += int'(s_stall);
    chk("tlbr_idx", 90'(s_idx), 90'(5));
    chk("tlbr_we", 90'(s_we), 90'(0));
    r_ack = 0; step();
    stall_cnt += int'(s_stall);
    chk("tlbr_entry_we", 90'(s_cew), 90'(1));
    chk("tlbr_entry_wdata", s_cewdata, xdata);
    step();
    chk("tlbr_entry_we_off", 90'(s_cew), 90'(0));
    chk("tlbr_stall_cycles", 90'(stall_cnt), 90'(2));

    probe_case(1'b0, 4'd6, 32'h8000_0000);
    probe_case(1'b1, 4'd9, 32'h0000_0009);

    // Random sequence with Wired=3, then TLBWR at Random=7.
    r_rst = 1; r_wired = 4'd3; step();
    r_rst = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("random_seq", 90'(s_random), 90'((i < 13) ? 15 - i : 15));
    end
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      if (m_rand == 7) found = 1;
      else step();
    end
    chk("random_reaches_7", 90'(found), 90'(1));
    r_op_valid = 1; r_op_type = 2'b11; r_index = 4'd2; r_entry = rand90(); step();
    r_op_valid = 0;
    for (int k = 0; k < 3; k++) begin
      r_ack = (k == 2); step();
      chk("tlbwr_idx", 90'(s_idx), 90'(7));
      chk("tlbwr_we", 90'(s_we), 90'(1));
    end
    r_ack = 0; step();
    chk("tlbwr_no_cp0_write", 90'(s_cew | s_ciw), 90'(0));

    // TLBWI with ack in the 4th BUSY cycle while op_valid toggles.
    stall_cnt = 0;
    r_op_valid = 1; r_op_type = 2'b10; r_index = 4'd11; r_entry = rand90(); step();
    stall_cnt += int'(s_stall);
    for (int k = 0; k < 4; k++) begin
      r_op_valid = 1'($urandom); r_op_type = 2'($urandom); r_ack = (k == 3); step();
      stall_cnt += int'(s_stall);
      chk("tlbwi_req_held", 90'(s_req), 90'(1));
    end
    r_op_valid = 0; r_ack = 0; step();
    stall_cnt += int'(s_stall);
    chk("tlbwi_stall_cycles", 90'(stall_cnt), 90'(5));

    // Reset in BUSY coinciding with ack.
    r_op_valid = 1; r_op_type = 2'b01; step();
    r_op_valid = 0; r_rst = 1; r_ack = 1; r_rdata = rand90(); step();
    r_rst = 0; r_ack = 0; step();
    chk("rst_busy_no_write", 90'(s_cew | s_ciw), 90'(0));
    chk("rst_busy_random", 90'(s_random), 90'(15));
    chk("rst_busy_idle", 90'(s_req | s_stall), 90'(0));

`ifdef TLB_OP_TIMEOUT_EN
    r_op_valid = 1; r_op_type = 2'b10; step();
    r_op_valid = 0;
    for (int k = 0; k < 16; k++) step();
    step();
    chk("timeout_err", 90'(s_err), 90'(1));
    chk("timeout_stall", 90'(s_stall), 90'(0));
    step();
    r_op_valid = 1; r_op_type = 2'b01; step();
    r_op_valid = 0;
    for (int k = 0; k < 16; k++) begin
      r_ack = (k == 15); step();
    end
    r_ack = 0; step();
    chk("ack16_err", 90'(s_err), 90'(0));
    chk("ack16_entry_we", 90'(s_cew), 90'(1));
    step();
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r_rst      = ($urandom_range(0, 299) == 0);
      r_op_valid = 1'($urandom);
      r_op_type  = 2'($urandom);
      r_index    = 4'($urandom);
      r_wired_we = ($urandom_range(0, 39) == 0);
      if (r_wired_we) r_wired = 4'($urandom);
      r_entry    = rand90();
      r_ack      = ($urandom_range(0, 2) != 0);
      r_rdata    = rand90();
      r_hit      = 1'($urandom);
      r_pidx     = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
